// File: rtl/x9_pkg.sv
// Shared definitions for the x9 fetch path.
// Covers the instruction width, the halt encoding and the fetch FSM states.
package x9_pkg;

  localparam int unsigned INSTR_W = 9;
  localparam logic [INSTR_W-1:0] HALT_WORD = 9'h1FF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  // Index width of a table with 'depth' entries; a 1-entry table still needs one bit.
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle carrying the fetch controls, LUT write port and instruction-memory link.
// 'master' is the surrounding core/bench; 'slave' is the fetch unit.
interface instr_fetch_if
  import x9_pkg::*;
#(
  parameter int unsigned PC_W      = 10,
  parameter int unsigned LUT_DEPTH = 16
);

  localparam int unsigned IDX_W = idx_width(LUT_DEPTH);

  logic               start;
  logic               stall;
  logic               branch_en;
  logic               taken;
  logic [IDX_W-1:0]   target_idx;
  logic               lut_we;
  logic [IDX_W-1:0]   lut_waddr;
  logic [PC_W-1:0]    lut_wdata;
  logic [INSTR_W-1:0] instr_in;
  logic [PC_W-1:0]    prog_ctr;
  logic [INSTR_W-1:0] instr_out;
  logic               valid;
  logic               done;

  modport master (
    output start, stall, branch_en, taken, target_idx,
    output lut_we, lut_waddr, lut_wdata, instr_in,
    input  prog_ctr, instr_out, valid, done
  );

  modport slave (
    input  start, stall, branch_en, taken, target_idx,
    input  lut_we, lut_waddr, lut_wdata, instr_in,
    output prog_ctr, instr_out, valid, done
  );

endinterface

// File: rtl/branch_lut.sv
// Branch-target table: one registered write port, one combinational read port.
// Synchronous active-low reset clears every entry.
module branch_lut
  import x9_pkg::*;
#(
  parameter int unsigned PC_W      = 10,
  parameter int unsigned LUT_DEPTH = 16,
  localparam int unsigned IDX_W    = idx_width(LUT_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [PC_W-1:0]  wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [PC_W-1:0]  rdata_c
);

  logic [PC_W-1:0] mem_q [LUT_DEPTH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q <= '{default: '0};
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC sequencing, one-bubble taken branches through a target LUT,
// stall hold and halt detection. All outputs come straight from registers.
module instr_fetch
  import x9_pkg::*;
#(
  parameter int unsigned PC_W      = 10,
  parameter int unsigned LUT_DEPTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_HALT = HALT;

  logic [1:0]         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;

  logic [PC_W-1:0]    lut_target_c;
  logic               lut_we_c;
  logic               branch_taken_c;

  // Table is only writable while the program is not running.
  assign lut_we_c = bus.lut_we && (state_q != ST_RUN);

  // A branch only counts when the instruction that reported it is live.
  assign branch_taken_c = (state_q == ST_RUN) && bus.branch_en && bus.taken && valid_q;

  branch_lut #(
    .PC_W      (PC_W),
    .LUT_DEPTH (LUT_DEPTH)
  ) u_lut (
    .clk     (clk),
    .reset   (reset),
    .we      (lut_we_c),
    .waddr   (bus.lut_waddr),
    .wdata   (bus.lut_wdata),
    .raddr   (bus.target_idx),
    .rdata_c (lut_target_c)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output selection: taken branch > stall > halt/increment.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    done_d  = done_q;

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (bus.start) begin
          state_d = ST_RUN;
          pc_d    = '0;
          valid_d = 1'b0;
          done_d  = 1'b0;
        end
      end

      ST_RUN: begin
        if (branch_taken_c) begin
          pc_d    = lut_target_c;
          valid_d = 1'b0;
        end else if (!bus.stall) begin
          if (bus.instr_in == HALT_WORD) begin
            state_d = ST_HALT;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            instr_d = bus.instr_in;
            valid_d = 1'b1;
            pc_d    = pc_q + PC_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.prog_ctr  = pc_q;
  assign bus.instr_out = instr_q;
  assign bus.valid     = valid_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a cycle-level reference model is compared on every
// falling edge, with hand-computed literal checks at the interesting points.
module tb_instr_fetch;

  localparam int unsigned PC_W      = 10;
  localparam int unsigned LUT_DEPTH = 16;
  localparam int unsigned DEPTH     = 1 << PC_W;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_if #(.PC_W(PC_W), .LUT_DEPTH(LUT_DEPTH)) bus();

  instr_fetch #(.PC_W(PC_W), .LUT_DEPTH(LUT_DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [8:0] mem [DEPTH];
  assign bus.instr_in = mem[bus.prog_ctr];

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  // Reference model state
  bit         m_running;
  int         m_pc;
  logic [8:0] m_iout;
  bit         m_valid;
  bit         m_done;
  int         m_lut [LUT_DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of the fetch rules, applied to the model.
  always @(posedge clk) begin : model
    logic [8:0] fetched;
    if (!reset) begin
      m_running = 1'b0;
      m_pc      = 0;
      m_iout    = '0;
      m_valid   = 1'b0;
      m_done    = 1'b0;
      m_lut     = '{default: 0};
    end else if (!m_running) begin
      if (bus.lut_we) m_lut[bus.lut_waddr] = int'(bus.lut_wdata);
      if (bus.start) begin
        m_running = 1'b1;
        m_pc      = 0;
        m_valid   = 1'b0;
        m_done    = 1'b0;
      end
    end else begin
      fetched = mem[m_pc];
      if (bus.branch_en && bus.taken && m_valid) begin
        m_pc    = m_lut[bus.target_idx];
        m_valid = 1'b0;
      end else if (!bus.stall) begin
        if (fetched == 9'h1FF) begin
          m_running = 1'b0;
          m_valid   = 1'b0;
          m_done    = 1'b1;
        end else begin
          m_iout  = fetched;
          m_valid = 1'b1;
          m_pc    = (m_pc + 1) % int'(DEPTH);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_prog_ctr",  32'(bus.prog_ctr),  32'(m_pc));
      chk("cyc_instr_out", 32'(bus.instr_out), 32'(m_iout));
      chk("cyc_valid",     32'(bus.valid),     32'(m_valid));
      chk("cyc_done",      32'(bus.done),      32'(m_done));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic fill_mem();
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = 9'(i % 256);
  endtask

  task automatic clear_inputs();
    bus.start      = 1'b0;
    bus.stall      = 1'b0;
    bus.branch_en  = 1'b0;
    bus.taken      = 1'b0;
    bus.target_idx = '0;
    bus.lut_we     = 1'b0;
    bus.lut_waddr  = '0;
    bus.lut_wdata  = '0;
  endtask

  task automatic branch(input int idx);
    bus.branch_en  = 1'b1;
    bus.taken      = 1'b1;
    bus.target_idx = 4'(idx);
  endtask

  task automatic run_to_done(input string name, input int budget);
    int n = 0;
    while (!bus.done && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(bus.done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    fill_mem();
    reset = 1'b0;
    tick();
    tick();
    reset  = 1'b1;
    cmp_en = 1'b1;
    chk("rst_pc",    32'(bus.prog_ctr),  32'd0);
    chk("rst_instr", 32'(bus.instr_out), 32'd0);
    chk("rst_valid", 32'(bus.valid),     32'd0);
    chk("rst_done",  32'(bus.done),      32'd0);

    // Straight-line program ending in a halt word
    mem[0] = 9'h010; mem[1] = 9'h011; mem[2] = 9'h012; mem[3] = 9'h1FF;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("s1_start_pc",    32'(bus.prog_ctr), 32'd0);
    chk("s1_start_valid", 32'(bus.valid),    32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("s1_instr", 32'(bus.instr_out), 32'(9'h010 + k));
      chk("s1_valid", 32'(bus.valid),     32'd1);
      chk("s1_pc",    32'(bus.prog_ctr),  32'(k + 1));
    end
    tick();
    chk("s1_done",    32'(bus.done),     32'd1);
    chk("s1_valid0",  32'(bus.valid),    32'd0);
    chk("s1_pc_hold", 32'(bus.prog_ctr), 32'd3);
    tick();
    chk("s1_done_held", 32'(bus.done),     32'd1);
    chk("s1_pc_held",   32'(bus.prog_ctr), 32'd3);

    // LUT write together with start; taken branch squashes a halt word on the wrong path
    fill_mem();
    mem[3]  = 9'h1FF;
    mem[41] = 9'h1FF;
    bus.lut_we = 1'b1; bus.lut_waddr = 4'd5; bus.lut_wdata = 10'd40; bus.start = 1'b1;
    tick();
    clear_inputs();
    chk("s2_restart_pc",   32'(bus.prog_ctr), 32'd0);
    chk("s2_restart_done", 32'(bus.done),     32'd0);
    ticks(3);
    chk("s2_at_pc2", 32'(bus.instr_out), 32'd2);
    branch(5);
    tick();
    clear_inputs();
    chk("s2_br_pc",    32'(bus.prog_ctr), 32'd40);
    chk("s2_br_valid", 32'(bus.valid),    32'd0);
    chk("s2_squash",   32'(bus.done),     32'd0);
    tick();
    chk("s2_tgt_instr", 32'(bus.instr_out), 32'h028);
    chk("s2_tgt_valid", 32'(bus.valid),     32'd1);
    tick();
    chk("s2_halt41", 32'(bus.prog_ctr), 32'd41);
    chk("s2_done",   32'(bus.done),     32'd1);

    // Stall hold, branch beating stall, bubble and not-taken branches
    fill_mem();
    mem[50] = 9'h1FF;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    ticks(7);
    chk("s3_pc7", 32'(bus.prog_ctr), 32'd7);
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("s3_stall_pc",    32'(bus.prog_ctr),  32'd7);
      chk("s3_stall_instr", 32'(bus.instr_out), 32'd6);
    end
    branch(5);
    tick();
    chk("s3_br_stall_pc", 32'(bus.prog_ctr), 32'd40);
    bus.stall = 1'b0;
    tick();
    chk("s3_bubble_pc", 32'(bus.prog_ctr), 32'd41);
    bus.taken = 1'b0;
    tick();
    chk("s3_nt_pc", 32'(bus.prog_ctr), 32'd42);
    clear_inputs();
    run_to_done("s3_reach_done", 40);
    chk("s3_halt_pc",    32'(bus.prog_ctr),  32'd50);
    chk("s3_halt_instr", 32'(bus.instr_out), 32'd49);

    // LUT write during RUN ignored; start during RUN ignored
    fill_mem();
    mem[35] = 9'h1FF;
    bus.lut_we = 1'b1; bus.lut_waddr = 4'd1; bus.lut_wdata = 10'd30;
    tick();
    clear_inputs();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    ticks(2);
    bus.lut_we = 1'b1; bus.lut_waddr = 4'd1; bus.lut_wdata = 10'd99;
    tick();
    bus.lut_we = 1'b0;
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("s4_start_ign", 32'(bus.prog_ctr), 32'd4);
    branch(1);
    tick();
    clear_inputs();
    chk("s4_old_lut", 32'(bus.prog_ctr), 32'd30);
    run_to_done("s4_reach_done", 20);
    chk("s4_halt_pc", 32'(bus.prog_ctr), 32'd35);

    // Restart from HALT, reset mid-RUN, zeroed LUT, PC wrap
    fill_mem();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("s5_restart_pc",   32'(bus.prog_ctr), 32'd0);
    chk("s5_restart_done", 32'(bus.done),     32'd0);
    ticks(12);
    chk("s5_pc12", 32'(bus.prog_ctr), 32'd12);
    reset = 1'b0;
    bus.start = 1'b1;
    branch(1);
    bus.lut_we = 1'b1; bus.lut_waddr = 4'd3; bus.lut_wdata = 10'd77;
    tick();
    reset = 1'b1;
    clear_inputs();
    chk("s5_rst_pc",    32'(bus.prog_ctr),  32'd0);
    chk("s5_rst_valid", 32'(bus.valid),     32'd0);
    chk("s5_rst_done",  32'(bus.done),      32'd0);
    chk("s5_rst_instr", 32'(bus.instr_out), 32'd0);
    mem[6] = 9'h1FF;
    bus.lut_we = 1'b1; bus.lut_waddr = 4'd2; bus.lut_wdata = 10'd1022; bus.start = 1'b1;
    tick();
    clear_inputs();
    ticks(2);
    branch(5);
    tick();
    clear_inputs();
    chk("s5_zero_lut", 32'(bus.prog_ctr), 32'd0);
    tick();
    branch(2);
    tick();
    clear_inputs();
    chk("s5_br_1022", 32'(bus.prog_ctr), 32'd1022);
    ticks(2);
    chk("s5_wrap_pc",    32'(bus.prog_ctr),  32'd0);
    chk("s5_wrap_instr", 32'(bus.instr_out), 32'h0FF);
    run_to_done("s5_reach_done", 20);
    chk("s5_halt_pc", 32'(bus.prog_ctr), 32'd6);

    tick();
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter PC_W, default 10, meaning program-counter and instruction-address width.
REQ-002 SHALL have parameter LUT_DEPTH, default 16, meaning branch-target lookup-table entries; index width is log2(LUT_DEPTH).
REQ-003 SHALL have ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  begin execution at PC 0.
- stall  in  1  hold PC and output instruction.
- branch_en  in  1  decode reports a branch in instr_out.
- taken  in  1  branch condition flag from the ALU.
- target_idx  in  log2(LUT_DEPTH)  LUT index of the branch target.
- lut_we  in  1  LUT write strobe.
- lut_waddr  in  log2(LUT_DEPTH)  LUT write index.
- lut_wdata  in  PC_W  LUT write data, an absolute PC.
- instr_in  in  9  combinational instruction-memory read data at prog_ctr.
- prog_ctr  out  PC_W  instruction-memory address.
- instr_out  out  9  registered instruction to decode.
- valid  out  1  instr_out holds a live instruction.
- done  out  1  program halted.

Function
REQ-004 SHALL implement FSM states IDLE, RUN and HALT.
REQ-005 IDLE->RUN on start; RUN->HALT on an unsquashed fetch of HALT_WORD (9'h1FF); HALT->RUN on start; no other transitions except reset.
REQ-006 On IDLE/HALT->RUN: prog_ctr SHALL be set to 0, and valid and done SHALL be set to 0.
REQ-007 In RUN, on each edge with stall=0 and no taken branch: instr_out<=instr_in, valid<=1, prog_ctr<=prog_ctr+1.
REQ-008 prog_ctr SHALL wrap from 2^PC_W-1 to 0 without a flag.
REQ-009 A taken branch (RUN, branch_en=1, taken=1, valid=1) SHALL set prog_ctr<=lut[target_idx] and valid<=0 for one cycle, squashing the wrong-path fetch.
REQ-010 branch_en with taken=0 SHALL behave as a normal increment.
REQ-011 In RUN, update priority SHALL be: taken branch > stall > increment.
REQ-012 Branch and stall asserted together SHALL result in the branch being taken.
REQ-013 With stall=1 and no taken branch, prog_ctr, instr_out and valid SHALL hold their values.
REQ-014 Fetching HALT_WORD in RUN (not stalled, not squashed) SHALL, on the same edge, set valid<=0 and done<=1, hold prog_ctr, and enter HALT.
REQ-015 A squashed HALT_WORD SHALL be ignored.
REQ-016 done SHALL stay 1 in HALT until start.
REQ-017 start in RUN SHALL be ignored.
REQ-018 LUT writes SHALL occur only in IDLE or HALT: lut[lut_waddr]<=lut_wdata when lut_we=1.
REQ-019 lut_we in RUN SHALL be ignored.
REQ-020 LUT reads SHALL be combinational.
REQ-021 A write and a start on the same edge SHALL commit the write, and execution SHALL begin with the updated LUT.
REQ-022 Fetch latency from prog_ctr to instr_out SHALL be 1 cycle.
REQ-023 Taken-branch penalty SHALL be 1 bubble cycle.

Reset
REQ-024 reset=0 at an edge SHALL force state=IDLE, prog_ctr=0, instr_out=0, valid=0, done=0, and all LUT entries=0.
REQ-025 Reset SHALL take priority over every other input, including mid-RUN and mid-branch.

Structure
REQ-026 Shared package x9_pkg SHALL hold INSTR_W=9, HALT_WORD=9'h1FF, and the fetch-state enum (IDLE, RUN, HALT).
REQ-027 The LUT SHALL be the sub-module branch_lut: write port plus one combinational read port, same clock and reset.
REQ-028 The FSM, PC and output registers SHALL reside in instr_fetch.

Verification
REQ-029 Reset, start, memory 0..3 = 9'h010,9'h011,9'h012,9'h1FF -> instr_out 010,011,012 on successive cycles with valid=1; done=1 one cycle after 1FF is fetched; prog_ctr holds 3.
REQ-030 In IDLE write lut[5]=40, start, branch_en=taken=1 with target_idx=5 while instr_out is at PC 2 -> next prog_ctr=40, valid=0 for one cycle, then the instruction at 40 appears valid.
REQ-031 Stall for 3 cycles at PC 7 -> prog_ctr=7 and instr_out unchanged for 3 cycles; branch+stall on the same edge -> branch taken.
REQ-032 lut_we in RUN writing lut[1]=99 -> lut[1] unchanged; a later taken branch via idx 1 goes to its old value.
REQ-033 reset=0 mid-RUN at PC 12 -> next edge: IDLE, prog_ctr=0, valid=0, done=0, LUT zeroed; start in RUN ignored; start from HALT restarts at PC 0 with done cleared.
